decode_queue: RTL

- Parametrised successor to the single-entry decode stage of the in-order front end. Sits between fetch and rename/dispatch.
- Decodes each accepted 32-bit instruction into register indices, immediate, ALU class, funct fields and an illegal flag.
- Queues decoded entries in a DEPTH-entry FIFO with a full valid/ready handshake on both sides.
- Adds capabilities the single-entry version lacks: configurable depth, occupancy count, pipeline flush, and deterministic decode of unsupported opcodes.

---
 rtl/decode_queue_if.sv | 40 ++++
 rtl/decode_queue.sv | 118 +++++++++++
 2 files changed

// File: rtl/decode_queue_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_queue_if : fetch-side and dispatch-side bus of the decode queue
// Revision 1.0
// ---------------------------------------------------------------------------
interface decode_queue_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 2
);
  logic [31:0]      instruction;
  logic [PC_W-1:0]  PC_in;
  logic             valid_in;
  logic             ready_in;
  logic             valid_out;
  logic             ready_out;
  logic [PC_W-1:0]  PC_out;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic [31:0]      imm;
  logic [2:0]       ALUOp;
  logic [6:0]       Opcode;
  logic [2:0]       func3;
  logic [6:0]       func7;
  logic             illegal;
  logic [CNT_W-1:0] count;

  modport slave (
    input  instruction, PC_in, valid_in, ready_out,
    output ready_in, valid_out, PC_out, rs1, rs2, rd, imm,
           ALUOp, Opcode, func3, func7, illegal, count
  );

  modport master (
    output instruction, PC_in, valid_in, ready_out,
    input  ready_in, valid_out, PC_out, rs1, rs2, rd, imm,
           ALUOp, Opcode, func3, func7, illegal, count
  );
endinterface
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_queue : RV32 instruction decoder feeding a DEPTH-entry decoded FIFO
// Revision 1.0
// ---------------------------------------------------------------------------
module decode_queue #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  wire logic      clk,
  input  wire logic      reset,
  input  wire logic      flush,
  decode_queue_if.slave  bus
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_ENT_W = PC_W + 5 + 5 + 5 + 32 + 3 + 7 + 3 + 7 + 1;

  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic [c_ENT_W-1:0] r_mem [DEPTH];

  logic [4:0]         w_rs1, w_rs2, w_rd;
  logic [31:0]        w_imm;
  logic [2:0]         w_aluop, w_func3;
  logic [6:0]         w_func7;
  logic               w_illegal;
  logic               w_push, w_pop, w_valid_out;
  logic [c_ENT_W-1:0] w_entry, w_head;

  wire logic [31:0] w_ins = bus.instruction;
  wire logic [31:0] w_imm_i = {{20{w_ins[31]}}, w_ins[31:20]};
  wire logic [31:0] w_imm_s = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
  wire logic [31:0] w_imm_b = {{19{w_ins[31]}}, w_ins[31], w_ins[7],
                               w_ins[30:25], w_ins[11:8], 1'b0};
  wire logic [31:0] w_imm_u = {w_ins[31:12], 12'b0};

  // Unused fields of each format stay at their zero defaults.
  always_comb begin
    w_rs1     = '0;
    w_rs2     = '0;
    w_rd      = '0;
    w_imm     = '0;
    w_aluop   = 3'b111;
    w_func3   = '0;
    w_func7   = '0;
    w_illegal = 1'b0;
    case (w_ins[6:0])
      7'b0010011: begin
        w_aluop = 3'b000; w_rs1 = w_ins[19:15]; w_rd = w_ins[11:7];
        w_imm = w_imm_i; w_func3 = w_ins[14:12];
      end
      7'b0110111: begin
        w_aluop = 3'b101; w_rd = w_ins[11:7]; w_imm = w_imm_u;
      end
      7'b0110011: begin
        w_aluop = 3'b001; w_rs1 = w_ins[19:15]; w_rs2 = w_ins[24:20];
        w_rd = w_ins[11:7]; w_func3 = w_ins[14:12]; w_func7 = w_ins[31:25];
      end
      7'b0000011: begin
        w_aluop = 3'b010; w_rs1 = w_ins[19:15]; w_rd = w_ins[11:7];
        w_imm = w_imm_i; w_func3 = w_ins[14:12];
      end
      7'b0100011: begin
        w_aluop = 3'b011; w_rs1 = w_ins[19:15]; w_rs2 = w_ins[24:20];
        w_imm = w_imm_s; w_func3 = w_ins[14:12];
      end
      7'b1100011: begin
        w_aluop = 3'b100; w_rs1 = w_ins[19:15]; w_rs2 = w_ins[24:20];
        w_imm = w_imm_b; w_func3 = w_ins[14:12];
      end
      7'b1100111: begin
        w_aluop = 3'b110; w_rs1 = w_ins[19:15]; w_rd = w_ins[11:7];
        w_imm = w_imm_i; w_func3 = w_ins[14:12];
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_entry = {bus.PC_in, w_rs1, w_rs2, w_rd, w_imm, w_aluop,
                    w_ins[6:0], w_func3, w_func7, w_illegal};

  assign w_valid_out  = (r_count != '0);
  assign bus.ready_in = (r_count != CNT_W'(DEPTH));
  assign w_push       = bus.valid_in & bus.ready_in;
  assign w_pop        = w_valid_out & bus.ready_out;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  // Reset takes priority over flush; both discard any same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head        = w_valid_out ? r_mem[r_rptr] : '0;
  assign bus.valid_out = w_valid_out;
  assign bus.count     = r_count;
  assign {bus.PC_out, bus.rs1, bus.rs2, bus.rd, bus.imm, bus.ALUOp,
          bus.Opcode, bus.func3, bus.func7, bus.illegal} = w_head;
endmodule
`default_nettype wire
